// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types and defaults for the MEM-stage data-memory access controller.
// Holds the FSM encoding, default timeout and the read data returned on a bus error.
package dmem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 64;
  localparam logic [31:0] DEFAULT_ERR_RDATA      = 32'h0000_0000;

  // A store wins when both memRead and memWrite are set, so either bit requests an access.
  function automatic logic is_access(input logic valid, input logic rd, input logic wr);
    return valid & (rd | wr);
  endfunction

endpackage

// File: rtl/dmem_access_ctrl_wait_timer.sv
// Wait-cycle counter for an outstanding data-memory request.
// tc flags the last cycle the controller may wait before declaring a bus error.
module dmem_wait_timer
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Clear dominates so a fresh request always starts counting from zero.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 16'd0;
    end else if (en) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory sequencer: issues req/ack accesses, stalls the upstream
// pipeline while one is outstanding, and reports a bus error on a missing ack.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        memwb_bubble,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic [1:0]  state_dbg
);

  // Handshake: dmem_req rises for one access and stays high, with we/addr/wdata
  // frozen, until the first cycle dmem_ack is sampled high (or the timer expires);
  // dmem_ack is only honoured while the request is outstanding.

  dmem_state_e state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic access;
  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  assign access = is_access(mem_valid, mem_read, mem_write);

  assign timer_clr = (state_q == IDLE);
  assign timer_en  = (state_q == WAIT) & ~dmem_ack;

  dmem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = addr;
          wdata_d = wdata;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // An ack landing on the terminal count still completes the access cleanly.
        if (dmem_ack) begin
          if (!we_q) begin
            rdata_d = dmem_rdata;
          end
          req_d   = 1'b0;
          state_d = DONE;
        end else if (timer_tc) begin
          err_d = 1'b1;
          if (!we_q) begin
            rdata_d = ERR_RDATA;
          end
          req_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The IDLE-cycle stall must be combinational so the access is held in MEM
  // on the very cycle it is first seen; reset overrides it immediately.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:    stall = access;
      WAIT:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
    stall = stall & rst;
  end

  assign memwb_bubble = stall;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign rdata        = rdata_q;
  assign bus_err      = err_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: directed vector table, reset/late-ack sequences
// and randomized accesses checked against a transaction-level reference model.
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        mem_valid, mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall, memwb_bubble;
  logic [31:0] rdata;
  logic        bus_err;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata;

  dmem_access_ctrl #(
    .TIMEOUT_CYCLES(T),
    .ERR_RDATA(ERR)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .memwb_bubble(memwb_bubble),
    .rdata(rdata), .bus_err(bus_err), .state_dbg(state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: an access waits until the k-th request cycle
  // acks it, unless k is 0 or beyond the timeout, in which case it gives up after T cycles.
  function automatic void ref_txn(input logic v, input logic rd, input logic wr, input int k,
                                  input logic [31:0] ad, input logic [31:0] rd_in,
                                  output int e_stall, output int e_req, output int e_err,
                                  output logic [31:0] rd_out);
    bit served;
    int wcyc;
    rd_out = rd_in;
    if (!(v && (rd || wr))) begin
      e_stall = 0; e_req = 0; e_err = 0;
    end else begin
      served  = (k >= 1) && (k <= T);
      wcyc    = served ? k : T;
      e_stall = 1 + wcyc;
      e_req   = wcyc;
      e_err   = served ? 0 : 1;
      if (!wr) rd_out = served ? ad : ERR;
    end
  endfunction

  // Driver + memory responder: presents one MEM-stage instruction and services
  // its request; returns once the pipeline is released (stall sampled low).
  task automatic run_txn(input logic v, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int k, input logic [31:0] ad,
                         output int n_stall, output int n_req, output int n_err,
                         output logic ok_bus, output logic ok_bub,
                         output logic [31:0] rd_done);
    int  reqc;
    int  cyc;
    bit  done;
    mem_valid = v; mem_read = rd; mem_write = wr;
    addr = a; wdata = wd; dmem_rdata = ad; dmem_ack = 1'b0;
    reqc = 0; cyc = 0; done = 0;
    n_stall = 0; n_req = 0; n_err = 0;
    ok_bus = 1'b1; ok_bub = 1'b1; rd_done = 32'hxxxx_xxxx;
    while (!done && cyc < 200) begin
      if (dmem_req === 1'b1) begin
        reqc++;
        dmem_ack = (reqc == k);
      end else begin
        dmem_ack = 1'b0;
      end
      @(negedge clk);
      if (stall === 1'b1) n_stall++;
      if (dmem_req === 1'b1) n_req++;
      if (bus_err === 1'b1) n_err++;
      if (memwb_bubble !== stall) ok_bub = 1'b0;
      if (dmem_req === 1'b1 && (dmem_we !== wr || dmem_addr !== a || dmem_wdata !== wd))
        ok_bus = 1'b0;
      if (stall !== 1'b1) begin
        done = 1;
        rd_done = rdata;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dmem_ack = 1'b0;
    if (!done) begin
      n_stall = -1;
      check("txn_release_timeout", 32'd0, 32'd1);
    end
  endtask

  typedef struct {
    logic        v, rd, wr;
    logic [31:0] a, wd;
    int          k;
    logic [31:0] ad;
    int          e_stall, e_req, e_err;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int          n_stall, n_req, n_err;
    logic        ok_bus, ok_bub;
    logic [31:0] rd_done;
    int          e_stall, e_req, e_err;
    logic [31:0] nrd;

    //            v     rd    wr    addr          wdata         k  ack data      stall req err rdata
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h1234_5678, 2, 1, 0, 32'h1234_5678};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, 5, 32'h9999_9999, 6, 5, 0, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0,        0, 32'h7777_7777, 9, 8, 1, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0104, 32'h0,        8, 32'hA5A5_A5A5, 9, 8, 0, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        2, 32'h1111_1111, 3, 2, 0, 32'h1111_1111};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0204, 32'h0,        3, 32'h2222_2222, 4, 3, 0, 32'h2222_2222};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0208, 32'h5,        1, 32'h3333_3333, 0, 0, 0, 32'h2222_2222};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_020C, 32'hBEEF_0001, 1, 32'h4444_4444, 2, 1, 0, 32'h2222_2222};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 32'h0000_0210, 32'h0,        1, 32'h5555_5555, 0, 0, 0, 32'h2222_2222};
    vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h0000_0214, 32'h0,        9, 32'h6666_6666, 9, 8, 1, 32'h0000_0000};

    // reset: drive a pending load to confirm stall is forced low
    rst = 1'b0;
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    addr = 32'h40; wdata = 32'h0; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #12;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_we", {31'd0, dmem_we}, 32'd0);
    check("rst_err", {31'd0, bus_err}, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_bubble", {31'd0, memwb_bubble}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // directed vector table
    foreach (vecs[i]) begin
      run_txn(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].k, vecs[i].ad,
              n_stall, n_req, n_err, ok_bus, ok_bub, rd_done);
      check($sformatf("vec%0d_stall", i), n_stall, vecs[i].e_stall);
      check($sformatf("vec%0d_req", i), n_req, vecs[i].e_req);
      check($sformatf("vec%0d_err", i), n_err, vecs[i].e_err);
      check($sformatf("vec%0d_rdata", i), rd_done, vecs[i].e_rd);
      check($sformatf("vec%0d_bus_stable", i), {31'd0, ok_bus}, 32'd1);
      check($sformatf("vec%0d_bubble", i), {31'd0, ok_bub}, 32'd1);
    end
    model_rdata = 32'h0;

    // late ack after the timeout: must be ignored in IDLE
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("late_ack_stall", {31'd0, stall}, 32'd0);
    check("late_ack_req", {31'd0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_state", {30'd0, state_dbg}, 32'd0);
    check("late_ack_rdata", rdata, model_rdata);
    check("late_ack_err", {31'd0, bus_err}, 32'd0);
    @(posedge clk); #1;

    // reset in the third WAIT cycle
    mem_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
    addr = 32'h300; wdata = 32'h0; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("mid_wait_req", {31'd0, dmem_req}, 32'd1);
    check("mid_wait_stall", {31'd0, stall}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", {31'd0, dmem_req}, 32'd0);
    check("async_rst_stall", {31'd0, stall}, 32'd0);
    check("async_rst_bubble", {31'd0, memwb_bubble}, 32'd0);
    @(negedge clk);
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_state", {30'd0, state_dbg}, 32'd0);
    dmem_ack = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("post_rst_ack_req", {31'd0, dmem_req}, 32'd0);
    check("post_rst_ack_stall", {31'd0, stall}, 32'd0);
    check("post_rst_ack_rdata", rdata, 32'd0);
    check("post_rst_ack_state", {30'd0, state_dbg}, 32'd0);
    model_rdata = 32'h0;

    // randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      logic        v, rd, wr;
      logic [31:0] a, wd, ad;
      int          k;
      v  = ($urandom_range(0, 7) != 0);
      rd = $urandom_range(0, 1);
      wr = $urandom_range(0, 1);
      a  = $urandom; wd = $urandom; ad = $urandom;
      k  = $urandom_range(0, T + 2);
      ref_txn(v, rd, wr, k, ad, model_rdata, e_stall, e_req, e_err, nrd);
      model_rdata = nrd;
      exp_q.push_back(nrd);
      run_txn(v, rd, wr, a, wd, k, ad, n_stall, n_req, n_err, ok_bus, ok_bub, rd_done);
      check($sformatf("rnd%0d_stall", n), n_stall, e_stall);
      check($sformatf("rnd%0d_req", n), n_req, e_req);
      check($sformatf("rnd%0d_err", n), n_err, e_err);
      check($sformatf("rnd%0d_rdata", n), rd_done, exp_q.pop_front());
      check($sformatf("rnd%0d_bus_stable", n), {31'd0, ok_bus}, 32'd1);
      check($sformatf("rnd%0d_bubble", n), {31'd0, ok_bub}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
